// File: rtl/sim8051_rom_loader.sv
// Program-ROM front end: packs a host byte stream into little-endian words,
// writes them from a base address, and arbitrates 8051 fetches around loads.
module sim8051_rom_loader #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [15:0] load_base,
    input  logic [16:0] load_len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        load_busy,
    output logic        load_done,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_ack,
    output logic        cpu_stall,
    output logic        rom_wr,
    output logic [15:0] rom_wr_addr,
    output logic [31:0] rom_wr_data,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    localparam logic [31:0] PAD_WORD = {4{PAD_BYTE}};

    state_t      state_q, state_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [16:0] remaining_q, remaining_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] pack_q, pack_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [31:0] cpu_data_q, cpu_data_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        cpu_ack_d   = 1'b0;
        cpu_data_d  = cpu_data_q;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (load_len == 17'd0) begin
                        state_d = DONE;
                    end else begin
                        cur_addr_d  = load_base;
                        remaining_d = load_len;
                        lane_d      = 2'd0;
                        pack_d      = PAD_WORD;
                        state_d     = FILL;
                    end
                end else if (cpu_req && !cpu_ack_q) begin
                    // ack must drop for a cycle so a held request is not re-served
                    cpu_ack_d  = 1'b1;
                    cpu_data_d = rom_data;
                end
            end
            FILL: begin
                if (byte_valid) begin
                    pack_d[{lane_q, 3'b000} +: 8] = byte_data;
                    remaining_d = remaining_q - 17'd1;
                    lane_d      = lane_q + 2'd1;
                    if (lane_q == 2'd3 || remaining_q == 17'd1)
                        state_d = WRITE;
                end
            end
            WRITE: begin
                cur_addr_d = cur_addr_q + 16'd4;
                lane_d     = 2'd0;
                pack_d     = PAD_WORD;
                state_d    = (remaining_q == 17'd0) ? DONE : FILL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready  = (state_q == FILL);
    assign load_busy   = (state_q != IDLE);
    assign load_done   = (state_q == DONE);
    assign cpu_stall   = load_busy;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_data    = cpu_data_q;
    assign rom_wr      = (state_q == WRITE);
    assign rom_wr_addr = rom_wr ? cur_addr_q : 16'd0;
    assign rom_wr_data = rom_wr ? pack_q : 32'd0;
    assign rom_addr    = cpu_addr;

endmodule

// File: tb/tb_sim8051_rom_loader.sv
// Scoreboard bench for sim8051_rom_loader with a byte-array ROM model.
module tb_sim8051_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] load_base = '0;
    logic [16:0] load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, load_busy, load_done;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_data;
    logic        cpu_ack, cpu_stall, rom_wr;
    logic [15:0] rom_wr_addr, rom_addr;
    logic [31:0] rom_wr_data, rom_data;

    sim8051_rom_loader #(.PAD_BYTE(8'h00)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .load_busy(load_busy), .load_done(load_done),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .rom_wr(rom_wr), .rom_wr_addr(rom_wr_addr), .rom_wr_data(rom_wr_data),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] ra1, ra2, ra3;
    always_comb begin
        ra1 = rom_addr + 16'd1;
        ra2 = rom_addr + 16'd2;
        ra3 = rom_addr + 16'd3;
        rom_data = {mem[ra3], mem[ra2], mem[ra1], mem[rom_addr]};
    end
    always @(posedge clk) begin
        if (rom_wr) begin
            for (int i = 0; i < 4; i++)
                mem[16'(rom_wr_addr + 16'(i))] <= rom_wr_data[i*8 +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [47:0] exp_wr[$];
    logic [31:0] exp_ack[$];
    logic [7:0]  bq[$];
    int done_cnt = 0, done_cyc = 0, ack_cnt = 0, ack_cyc = 0, busy_cnt = 0;
    int st_cyc = 0;
    logic prev_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // monitor: pops expectations whenever the DUT writes or acknowledges
    always @(negedge clk) begin
        if (rst) begin
            if (rom_wr) begin
                chk("rdy_in_write", 32'(byte_ready), 32'd0);
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr", {16'd0, rom_wr_addr}, 32'hFFFFFFFF);
                end else begin
                    logic [47:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", {16'd0, rom_wr_addr}, {16'd0, e[47:32]});
                    chk("wr_data", rom_wr_data, e[31:0]);
                end
            end
            if (cpu_ack) begin
                chk("ack_while_stall", 32'(cpu_stall), 32'd0);
                chk("ack_b2b", 32'(prev_ack), 32'd0);
                if (exp_ack.size() == 0)
                    chk("unexpected_ack", cpu_data, 32'hDEADBEEF);
                else
                    chk("ack_data", cpu_data, exp_ack.pop_front());
                ack_cnt++;
                ack_cyc = cyc;
            end
            prev_ack = cpu_ack;
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (load_busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] base, input logic [16:0] len);
        load_base  = base;
        load_len   = len;
        load_start = 1'b1;
        st_cyc     = cyc;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input bit gap);
        foreach (bq[i]) begin
            int t;
            logic rdy;
            t = 0;
            byte_valid = 1'b1;
            byte_data  = bq[i];
            forever begin
                @(negedge clk);
                rdy = byte_ready;
                tick();
                if (rdy) break;
                t++;
                if (t > 50) begin
                    chk("byte_timeout", 32'(t), 32'd0);
                    break;
                end
            end
            byte_valid = 1'b0;
            if (gap) tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int d0, t;
        d0 = done_cnt;
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("done_pulse", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_ack();
        int a0, t;
        a0 = ack_cnt;
        t = 0;
        while (ack_cnt == a0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("ack_seen", 32'(ack_cnt - a0), 32'd1);
    endtask

    initial begin
        int b0, k, dc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // reset with start and request asserted
        load_start = 1'b1;
        cpu_req    = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_load_busy", 32'(load_busy), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rom_wr", 32'(rom_wr), 32'd0);
        chk("rst_cpu_data", cpu_data, 32'd0);
        chk("rst_wr_addr", {16'd0, rom_wr_addr}, 32'd0);
        chk("rst_wr_data", rom_wr_data, 32'd0);
        tick();
        rst = 1'b1;
        load_start = 1'b0;
        cpu_req = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_busy", 32'(load_busy), 32'd0);
        tick();

        // aligned 8-byte load
        exp_wr.push_back({16'h0100, 32'h44332211});
        exp_wr.push_back({16'h0104, 32'h88776655});
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        b0 = busy_cnt;
        start_load(16'h0100, 17'd8);
        send(1'b0);
        wait_done();
        chk("done_latency", 32'(done_cyc - st_cyc), 32'd11);
        chk("busy_window", 32'(busy_cnt - b0), 32'd11);

        // back-to-back fetches from a held request
        cpu_addr = 16'h0104;
        repeat (3) exp_ack.push_back(32'h88776655);
        cpu_req = 1'b1;
        k = cyc;
        wait_ack();
        chk("fetch_lat", 32'(ack_cyc - k), 32'd1);
        wait_ack();
        wait_ack();
        chk("fetch_rate", 32'(ack_cyc - k), 32'd5);
        cpu_req = 1'b0;
        tick();

        // partial final word
        exp_wr.push_back({16'h0200, 32'hDDCCBBAA});
        exp_wr.push_back({16'h0204, 32'h000000EE});
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        start_load(16'h0200, 17'd5);
        send(1'b0);
        wait_done();
        tick();

        // zero-length load
        start_load(16'h0400, 17'd0);
        wait_done();
        chk("len0_latency", 32'(done_cyc - st_cyc), 32'd1);
        tick();

        // address wrap with host backpressure
        exp_wr.push_back({16'hFFFC, 32'h04030201});
        exp_wr.push_back({16'h0000, 32'h08070605});
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        start_load(16'hFFFC, 17'd8);
        send(1'b1);
        wait_done();
        tick();

        // fetch collides with load_start, served after the load
        cpu_addr = 16'h0100;
        cpu_req  = 1'b1;
        exp_wr.push_back({16'h0100, 32'h8D7C6B5A});
        exp_ack.push_back(32'h8D7C6B5A);
        bq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        start_load(16'h0100, 17'd4);
        send(1'b0);
        wait_done();
        dc = done_cyc;
        wait_ack();
        chk("ack_after_idle", 32'(ack_cyc - dc), 32'd2);
        cpu_req = 1'b0;
        tick();
        tick();
        chk("cpu_data_hold", cpu_data, 32'h8D7C6B5A);

        // reset mid-load drops the partial word
        bq = '{8'hC1, 8'hC2};
        start_load(16'h0300, 17'd4);
        send(1'b0);
        rst = 1'b0;
        tick();
        chk("midrst_busy", 32'(load_busy), 32'd0);
        chk("midrst_wr", 32'(rom_wr), 32'd0);
        rst = 1'b1;
        tick();
        exp_wr.push_back({16'h0300, 32'h04030201});
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        start_load(16'h0300, 17'd4);
        send(1'b0);
        wait_done();

        repeat (5) tick();
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sim8051_rom_loader.md
Name: sim8051_rom_loader

Overview:
Sequencing controller and arbiter in front of the simulation program ROM (32-bit read port, 4-byte write port). It accepts a host byte stream (valid/ready) and packs it into little-endian 32-bit words. It writes those words into the ROM from a programmable base address. While a load is in progress it holds off 8051 instruction fetches; otherwise it serves fetches with a registered one-cycle acknowledge.

Parameters:
PAD_BYTE, 8'h00, value placed in unfilled byte lanes of the final partial word

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
load_start  in  1  single-cycle pulse; starts a load (honoured only in IDLE)
load_base  in  16  ROM byte address of the first loaded byte; sampled with load_start
load_len  in  17  byte count, 0..65536; sampled with load_start
byte_valid  in  1  host byte available
byte_data  in  8  host byte
byte_ready  out  1  controller accepts a byte this cycle
load_busy  out  1  load in progress (any state except IDLE)
load_done  out  1  one-cycle pulse at load completion
cpu_req  in  1  fetch request; held until cpu_ack
cpu_addr  in  16  fetch byte address
cpu_data  out  32  fetched word, valid with cpu_ack
cpu_ack  out  1  one-cycle fetch acknowledge
cpu_stall  out  1  fetch blocked (equals load_busy)
rom_wr  out  1  ROM write strobe
rom_wr_addr  out  16  ROM write address
rom_wr_data  out  32  ROM write word; byte0 in [7:0]
rom_addr  out  16  ROM read address
rom_data  in  32  ROM read data, combinational from rom_addr

Behaviour:
- Reset (rst=0 at a clock edge): state goes to IDLE. byte_ready, load_busy, load_done, cpu_ack, rom_wr all 0. cpu_data, rom_wr_addr, rom_wr_data all 0. Internal address, count, lane and pack registers are cleared. Reset mid-load discards any partially packed word; no ROM write is issued for it.
- States are IDLE, FILL, WRITE and DONE.
- IDLE:
  - load_start=1 and load_len=0: go to DONE.
  - load_start=1 and load_len>0: latch cur_addr=load_base and remaining=load_len, set lane=0, set the pack word to all PAD_BYTE, go to FILL.
  - load_start has priority over cpu_req in the same cycle. No cpu_ack is issued for that request; the CPU keeps cpu_req high.
- FILL:
  - byte_ready=1.
  - On byte_valid & byte_ready: write byte_data into lane[lane], decrement remaining, increment lane.
  - Go to WRITE when the accepted byte lands in lane 3 or remaining becomes 0.
- WRITE:
  - byte_ready=0. rom_wr=1 for exactly one cycle, with rom_wr_addr=cur_addr and rom_wr_data=pack word (unfilled lanes = PAD_BYTE).
  - Then cur_addr += 4 (mod 2^16; wrap from 16'hFFFC to 16'h0000 is legal), lane=0, pack word reset to PAD_BYTE.
  - Next state is DONE if remaining=0, else FILL.
- DONE: load_done=1 for one cycle, then IDLE.
- Ignored inputs:
  - load_start outside IDLE has no effect.
  - byte_valid outside FILL is not consumed; the host holds the byte.
- ROM addressing: rom_addr = cpu_addr in all states. The ROM's own 4-byte write wraps modulo 2^16.
- Fetch path:
  - In IDLE with cpu_req=1, no load_start and cpu_ack=0: next cycle cpu_ack=1 and cpu_data=rom_data sampled at the request edge. Latency is 1 cycle.
  - After an ack, cpu_ack returns to 0 for at least one cycle. Back-to-back requests therefore take 2 cycles each.
  - cpu_data holds its value until the next ack.
  - While load_busy=1: cpu_ack=0 and cpu_stall=1.
- Throughput: 4 bytes per 5 cycles (4 FILL cycles plus 1 WRITE) at full host rate.
- Host stalls (byte_valid=0) in FILL simply extend FILL. No timeout.

Test Plan:
1. Reset behaviour: rst=0 for 2 cycles with load_start=1 and cpu_req=1 → every output is 0. After rst=1, load_busy=0.
2. Aligned load: load_base=16'h0100, load_len=8, bytes 11..88 streamed continuously → exactly two rom_wr pulses: addr 0100 data 44332211, then addr 0104 data 88776655. load_done pulses once, 11 cycles after load_start, and load_busy covers that whole window.
3. Partial final word: load_len=5, bytes AA,BB,CC,DD,EE, PAD_BYTE=00 → writes 0x DDCCBBAA then 0x000000EE at base+4. load_len=0 → load_done the next cycle with no rom_wr.
4. Wrap and backpressure: load_base=16'hFFFC, load_len=8, byte_valid toggled every other cycle → writes at FFFC then 0000. No byte is lost or duplicated. byte_ready=0 during WRITE.
5. Arbitration: cpu_req=1 with cpu_addr=0x0100 in the same cycle as load_start → no cpu_ack while load_busy=1. The first cpu_ack comes the cycle after returning to IDLE, with cpu_data equal to the newly loaded word.
6. Reset mid-load: drive rst=0 after 2 of 4 bytes are accepted → no rom_wr, state IDLE. A new load_start then completes normally.
